// File: rtl/gpu_cmd_queue_if.sv
// gpu_cmd_queue_if: raster command types and the CPU/rasteriser bus of gpu_cmd_queue.
// Defining GPU_CMDQ_STATS_EN adds the cmdq_issued counter to the bus.
package gpu_cmd_pkg;
    typedef enum logic [2:0] {CMD_NOP, CMD_CLEAR, CMD_FILL, CMD_LINE, CMD_RECT} raster_command_t;
    typedef struct packed {
        raster_command_t cmd;
        logic [7:0]      x0, y0, x1, y1;
        logic [2:0]      colour;
    } cmd_entry_t;
endpackage

interface gpu_cmd_queue_if #(parameter int DEPTH = 4);
    import gpu_cmd_pkg::*;
    logic                   cmd_valid, cmd_ready, cmdq_flush, cmdq_idle, gpu_execute_request, gpu_busy;
    raster_command_t        cmd, gpu_command;
    logic [7:0]             cmd_x0, cmd_y0, cmd_x1, cmd_y1, gpu_x0, gpu_y0, gpu_x1, gpu_y1;
    logic [2:0]             cmd_colour, gpu_colour;
    logic [$clog2(DEPTH):0] cmdq_count;
`ifdef GPU_CMDQ_STATS_EN
    logic [15:0]            cmdq_issued;
    modport master (
        output cmd_valid, cmd, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, cmdq_flush, gpu_busy,
        input  cmd_ready, cmdq_count, cmdq_idle, gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1,
               gpu_colour, gpu_execute_request, cmdq_issued
    );
    modport slave (
        input  cmd_valid, cmd, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, cmdq_flush, gpu_busy,
        output cmd_ready, cmdq_count, cmdq_idle, gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1,
               gpu_colour, gpu_execute_request, cmdq_issued
    );
`else
    modport master (
        output cmd_valid, cmd, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, cmdq_flush, gpu_busy,
        input  cmd_ready, cmdq_count, cmdq_idle, gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1,
               gpu_colour, gpu_execute_request
    );
    modport slave (
        input  cmd_valid, cmd, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour, cmdq_flush, gpu_busy,
        output cmd_ready, cmdq_count, cmdq_idle, gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1,
               gpu_colour, gpu_execute_request
    );
`endif
endinterface

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: FIFO of raster commands issued one at a time to a busy-handshaking rasteriser.
// Defining GPU_CMDQ_STATS_EN adds a 16-bit wrapping count of issued commands (cmdq_issued).
module gpu_cmd_queue #(parameter int DEPTH = 4) (
    input  logic           clk,
    input  logic           rst_async,
    gpu_cmd_queue_if.slave bus_io
);
    import gpu_cmd_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;
    state_t        state_q;
    cmd_entry_t    mem_q [DEPTH];
    cmd_entry_t    in_entry, head, out_q;
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          req_q, push, pop, empty;

    assign empty             = count_q == '0;
    assign in_entry          = '{bus_io.cmd, bus_io.cmd_x0, bus_io.cmd_y0, bus_io.cmd_x1, bus_io.cmd_y1, bus_io.cmd_colour};
    // An empty queue forwards the incoming command so the first issue costs one cycle
    assign head              = empty ? in_entry : mem_q[rd_q];
    assign bus_io.cmd_ready  = count_q != CW'(DEPTH) && !bus_io.cmdq_flush;
    assign push              = bus_io.cmd_valid && bus_io.cmd_ready;
    assign pop               = state_q == IDLE && !bus_io.gpu_busy && !bus_io.cmdq_flush && (!empty || push);
    assign count_d           = bus_io.cmdq_flush ? '0 : count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_entry;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q <= IDLE;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            req_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            count_q <= count_d;
            wr_q    <= push ? wr_q + AW'(1) : wr_q;
            rd_q    <= bus_io.cmdq_flush ? wr_q : pop ? rd_q + AW'(1) : rd_q;
            req_q   <= pop;
            out_q   <= pop ? head : out_q;
            state_q <= state_q == IDLE  ? (pop ? ISSUE : IDLE) :
                       state_q == ISSUE ? GUARD :
                       state_q == GUARD ? WAIT :
                       bus_io.gpu_busy  ? WAIT : IDLE;
        end
    end

    assign bus_io.gpu_execute_request = req_q;
    assign bus_io.gpu_command         = out_q.cmd;
    assign bus_io.gpu_x0              = out_q.x0;
    assign bus_io.gpu_y0              = out_q.y0;
    assign bus_io.gpu_x1              = out_q.x1;
    assign bus_io.gpu_y1              = out_q.y1;
    assign bus_io.gpu_colour          = out_q.colour;
    assign bus_io.cmdq_count          = count_q;
    assign bus_io.cmdq_idle           = empty && state_q == IDLE && !bus_io.gpu_busy;

`ifdef GPU_CMDQ_STATS_EN
    logic [15:0] issued_q;
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) issued_q <= '0;
        else           issued_q <= state_q == ISSUE ? issued_q + 16'd1 : issued_q;
    end
    assign bus_io.cmdq_issued = issued_q;
`endif
endmodule

// File: doc/gpu_cmd_queue.md
GPU_CMD_QUEUE -- requirements
Module: gpu_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 clk  input  1  50 MHz system clock; all state changes on rising edge.
REQ-003 rst_async  input  1  asynchronous active-high reset.
REQ-004 cmd_valid  input  1  CPU offers one raster command this cycle.
REQ-005 cmd  input  raster_command_t  command opcode from the common package.
REQ-006 cmd_x0, cmd_y0, cmd_x1, cmd_y1  input  8 each  command coordinates.
REQ-007 cmd_colour  input  3  command colour.
REQ-008 cmd_ready  output  1  queue accepts a command this cycle (not full and no flush).
REQ-009 cmdq_flush  input  1  discard all queued, not yet issued commands.
REQ-010 cmdq_count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-011 cmdq_idle  output  1  queue empty, FSM in IDLE and gpu_busy low.
REQ-012 gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour  output  as cmd_*  command presented to the rasteriser.
REQ-013 gpu_execute_request  output  1  single-cycle start pulse to the rasteriser.
REQ-014 gpu_busy  input  1  rasteriser executing.

Function
REQ-015 Push: cmd_valid and cmd_ready at the clock edge shall write all cmd_* fields into the FIFO tail.
REQ-016 cmd_ready shall be low when cmdq_count == DEPTH, even if a pop occurs in the same cycle.
REQ-017 A push on an empty queue with the FSM in IDLE and gpu_busy low shall enter ISSUE on the next edge; first-command latency is 1 cycle from accept to the gpu_execute_request pulse.
REQ-018 FSM states: IDLE, ISSUE, GUARD, WAIT.
REQ-019 IDLE -> ISSUE when the queue is non-empty and gpu_busy is low; the head is popped into the gpu_* output registers on this edge.
REQ-020 ISSUE: gpu_execute_request high for exactly this one cycle; the next state is always GUARD.
REQ-021 GUARD: one cycle with gpu_busy ignored, covering the busy-rise latency; the next state is always WAIT.
REQ-022 WAIT -> IDLE when gpu_busy is low; otherwise remain in WAIT.
REQ-023 gpu_execute_request shall never assert while gpu_busy is high or outside ISSUE.
REQ-024 gpu_* data outputs shall change only on the IDLE -> ISSUE edge and be held stable until the next issue.
REQ-025 Back-to-back commands: minimum issue spacing is 4 cycles (ISSUE, GUARD, WAIT, IDLE).
REQ-026 Simultaneous push and pop: cmdq_count is unchanged; the FIFO order is preserved.
REQ-027 Pointers shall wrap modulo DEPTH with no loss or duplication.
REQ-028 cmdq_flush shall empty the FIFO on the next edge; a same-cycle push is dropped; a same-cycle IDLE -> ISSUE is suppressed.
REQ-029 cmdq_flush shall not abort an in-flight command: an FSM in ISSUE, GUARD or WAIT continues normally.

Reset
REQ-030 Reset shall set FSM=IDLE, cmdq_count=0, pointers=0, gpu_execute_request=0, gpu_* data=0 (gpu_command = the enum value 0), and cmd_ready=1 once released.
REQ-031 Reset mid-operation shall deassert gpu_execute_request immediately (asynchronously) and discard all queued entries.

Configuration
REQ-032 Macro GPU_CMDQ_STATS_EN defined: the block shall add output cmdq_issued (16 bits), incremented on every ISSUE cycle, wrapping at 0xFFFF -> 0, reset to 0.
REQ-033 Macro GPU_CMDQ_STATS_EN undefined: the port and counter shall be absent; all other behaviour shall be identical.

Verification
REQ-034 Push FILL colour 3'b101 into an idle queue with gpu_busy=0 -> gpu_execute_request pulses 1 cycle on the cycle after accept, gpu_colour=3'b101.
REQ-035 Push 4 commands (DEPTH=4) with gpu_busy held high -> cmd_ready=0 and cmdq_count=4; a 5th push is ignored; release busy -> the 4 commands issue in order, each at least 4 cycles apart.
REQ-036 gpu_busy rises 1 cycle after each request and falls 20 cycles later -> no request while busy, and the gpu_* data is stable throughout.
REQ-037 Queue 3 commands, assert cmdq_flush during WAIT -> cmdq_count=0 next cycle, the in-flight command completes, and no further requests are issued.
REQ-038 Assert rst_async during ISSUE -> gpu_execute_request=0 immediately and cmdq_count=0; after release cmdq_idle=1.
REQ-039 Build with GPU_CMDQ_STATS_EN, issue 3 commands -> cmdq_issued=3; preload the counter at 0xFFFF and issue 1 -> cmdq_issued=0.
